// File: rtl/fft_pkg.sv
// Shared types and constants for the streaming parallel-4 FFT pipeline.
package fft_pkg;

   // Smallest r such that 2**r >= v; clog2(1) == 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   localparam int NFFT   = 128;
   localparam int PAR    = 4;
   localparam int WPF    = NFFT / PAR;
   localparam int IDX_W  = clog2(WPF);
   localparam int LAT    = 40;
   localparam int FCNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

endpackage

// File: rtl/fft_vld_shreg.sv
// Enabled valid-tracking shift register: one bit per pipeline slot.
// It advances only when the pipeline advances, so its output lines up with the
// data leaving the last stage. It also reports whether any slot is occupied now
// and whether any slot will still be occupied after the next shift.
module fft_vld_shreg #(
   parameter int DEPTH = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic dout,
   output logic any,
   output logic next_any
);

   logic [DEPTH-1:0] sr;
   logic [DEPTH-1:0] shifted;

   generate
      if (DEPTH == 1) begin : g_one
         assign shifted = din;
      end else begin : g_many
         assign shifted = {sr[DEPTH-2:0], din};
      end
   endgenerate

   // Shift the occupancy bits in step with the pipeline clock-enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr <= '0;
      end else if (en) begin
         sr <= shifted;
      end
   end

   assign dout     = sr[DEPTH-1];
   assign any      = |sr;
   assign next_any = |shifted;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the parallel-4 FFT pipeline. It gates the pipeline
// clock-enable, numbers the input words within each frame, and tracks slot
// occupancy to mark valid output words and frame boundaries. On a flush it
// drains the pipeline, but only once the current input frame is complete.
module fft_frame_ctrl #(
   parameter int NFFT   = fft_pkg::NFFT,
   parameter int PAR    = fft_pkg::PAR,
   parameter int LAT    = fft_pkg::LAT,
   parameter int IDX_W  = fft_pkg::IDX_W,
   parameter int FCNT_W = fft_pkg::FCNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic              pipe_en,
   output logic [IDX_W-1:0]  in_idx,
   output logic              out_valid,
   output logic              out_sof,
   output logic              out_eof,
   output logic              busy,
   output logic [FCNT_W-1:0] frame_cnt
);

   import fft_pkg::*;

   localparam int WPF = NFFT / PAR;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPF - 1);

   state_t           state;
   logic             flush_pend;
   logic [IDX_W-1:0] out_idx;
   logic             fire;
   logic             flush_req;
   logic             at_boundary;
   logic             sr_dout;
   logic             sr_any;
   logic             sr_next_any;

   assign in_ready  = (state != DRAIN);
   assign fire      = in_valid & in_ready;
   assign pipe_en   = fire | (state == DRAIN);
   assign out_valid = pipe_en & sr_dout;
   assign out_sof   = out_valid & (out_idx == '0);
   assign out_eof   = out_valid & (out_idx == LAST_IDX);
   assign busy      = sr_any;

   // A drain may only start on a frame boundary: either the last word of the
   // frame is being accepted now, or no word is arriving and nothing is partial.
   assign flush_req   = flush | flush_pend;
   assign at_boundary = (fire & (in_idx == LAST_IDX)) | (~fire & (in_idx == '0));

   fft_vld_shreg #(
      .DEPTH (LAT)
   ) u_vld (
      .clk      (clk),
      .rst      (rst),
      .en       (pipe_en),
      .din      (fire),
      .dout     (sr_dout),
      .any      (sr_any),
      .next_any (sr_next_any)
   );

   // Sequence IDLE/RUN/DRAIN and remember a flush that arrived mid-frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fire) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (flush_req && at_boundary) begin
                  state      <= DRAIN;
                  flush_pend <= 1'b0;
               end else if (flush) begin
                  flush_pend <= 1'b1;
               end
            end
            DRAIN: begin
               if (!sr_next_any) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Number accepted words within the frame; the datapath uses this index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_idx <= '0;
      end else if (fire) begin
         in_idx <= (in_idx == LAST_IDX) ? '0 : in_idx + 1'b1;
      end
   end

   // Number valid output words within the frame to place the SOF/EOF markers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_idx <= '0;
      end else if (out_valid) begin
         out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
      end
   end

   // Count completed output frames; wraps at the counter width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
      end else if (out_eof) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl. A behavioural model predicts the
// outputs on every cycle, and directed scenarios pin key cycles to literal values.
module tb_fft_frame_ctrl;

   localparam int LAT = 40;
   localparam int WPF = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       flush = 1'b0;
   logic       in_ready;
   logic       pipe_en;
   logic [4:0] in_idx;
   logic       out_valid;
   logic       out_sof;
   logic       out_eof;
   logic       busy;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   fft_frame_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .pipe_en   (pipe_en),
      .in_idx    (in_idx),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Cycle counter used only in messages.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Behavioural model: the operating mode, a history of what entered the
   // pipeline on each enabled cycle, and totals of accepted and emitted words.
   int m_mode;        // 0 idle, 1 run, 2 drain
   bit m_pend;
   int m_in_cnt;
   int m_out_cnt;
   int m_inflight;
   bit m_hist[$];

   bit e_ready, e_fire, e_pen, e_ov, e_sof, e_eof, e_busy, e_go;

   task automatic model_reset();
      m_mode = 0;
      m_pend = 0;
      m_in_cnt = 0;
      m_out_cnt = 0;
      m_inflight = 0;
      m_hist.delete();
   endtask

   // Compare the DUT against the model on each falling edge, then advance
   // the model to reflect the upcoming rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         model_reset();
         check_output("rst_in_ready", int'(in_ready), 1);
         check_output("rst_pipe_en", int'(pipe_en), 0);
         check_output("rst_out_valid", int'(out_valid), 0);
         check_output("rst_busy", int'(busy), 0);
         check_output("rst_frame_cnt", int'(frame_cnt), 0);
      end else begin
         e_ready = (m_mode != 2);
         e_fire  = in_valid && e_ready;
         e_pen   = e_fire || (m_mode == 2);
         e_ov    = e_pen && (m_hist.size() == LAT) && m_hist[0];
         e_sof   = e_ov && ((m_out_cnt % WPF) == 0);
         e_eof   = e_ov && ((m_out_cnt % WPF) == WPF - 1);
         e_busy  = (m_inflight > 0);
         check_output("m_in_ready", int'(in_ready), int'(e_ready));
         check_output("m_pipe_en", int'(pipe_en), int'(e_pen));
         check_output("m_out_valid", int'(out_valid), int'(e_ov));
         check_output("m_out_sof", int'(out_sof), int'(e_sof));
         check_output("m_out_eof", int'(out_eof), int'(e_eof));
         check_output("m_busy", int'(busy), int'(e_busy));
         check_output("m_in_idx", int'(in_idx), m_in_cnt % WPF);
         check_output("m_frame_cnt", int'(frame_cnt), (m_out_cnt / WPF) % 65536);
         e_go = (flush || m_pend) &&
                ((e_fire && (m_in_cnt % WPF) == WPF - 1) || (!e_fire && (m_in_cnt % WPF) == 0));
         if (e_pen) begin
            m_hist.push_back(e_fire);
            if (m_hist.size() > LAT) void'(m_hist.pop_front());
         end
         m_in_cnt   += int'(e_fire);
         m_out_cnt  += int'(e_ov);
         m_inflight += int'(e_fire) - int'(e_ov);
         case (m_mode)
            0: if (e_fire) m_mode = 1;
            1: begin
               if (e_go) begin
                  m_mode = 2;
                  m_pend = 0;
               end else if (flush) begin
                  m_pend = 1;
               end
            end
            default: if (m_inflight == 0) m_mode = 0;
         endcase
      end
   end

   // Drive one cycle of inputs just after the rising edge; return at the falling edge.
   task automatic apply_stimulus(input logic v, input logic f);
      @(posedge clk);
      #1;
      in_valid = v;
      flush = f;
      @(negedge clk);
   endtask

   // Run a drain from its first cycle until the controller accepts again.
   task automatic run_drain(input int flush_at, input int valid_for,
                            output int pe_cnt, output int last_eof, output int done);
      pe_cnt = 0;
      last_eof = 0;
      done = 0;
      for (int i = 0; i < 100; i++) begin
         apply_stimulus(i < valid_for, i == flush_at);
         if (i == 0) check_output("drain_first_in_ready", int'(in_ready), 0);
         if (in_ready) begin
            done = 1;
            break;
         end
         pe_cnt += int'(pipe_en);
         if (out_valid) last_eof = int'(out_eof);
      end
   endtask

   int pe_cnt, last_eof, done;

   initial begin
      // Reset asserted, then released.
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_output("t1_in_ready_low", int'(in_ready), 1);
      check_output("t1_busy_low", int'(busy), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_output("t1_in_ready", int'(in_ready), 1);
      check_output("t1_pipe_en", int'(pipe_en), 0);
      check_output("t1_out_valid", int'(out_valid), 0);
      check_output("t1_busy", int'(busy), 0);
      check_output("t1_frame_cnt", int'(frame_cnt), 0);

      // Back-to-back stream of three frames, then a flush at the boundary.
      for (int k = 0; k < 96; k++) begin
         apply_stimulus(1'b1, 1'b0);
         if (k == 33) check_output("t2_in_idx33", int'(in_idx), 1);
         if (k == 39) check_output("t2_ov39", int'(out_valid), 0);
         if (k == 40) begin
            check_output("t2_ov40", int'(out_valid), 1);
            check_output("t2_sof40", int'(out_sof), 1);
         end
         if (k == 71) check_output("t2_eof71", int'(out_eof), 1);
         if (k == 72) begin
            check_output("t2_sof72", int'(out_sof), 1);
            check_output("t2_fcnt72", int'(frame_cnt), 1);
         end
      end
      apply_stimulus(1'b0, 1'b1);
      check_output("t2_flush_in_ready", int'(in_ready), 1);
      // A flush pulse during the drain must not disturb it.
      run_drain(5, 0, pe_cnt, last_eof, done);
      check_output("t2_drain_done", done, 1);
      check_output("t2_drain_pe", pe_cnt, 40);
      check_output("t2_drain_last_eof", last_eof, 1);
      check_output("t2_fcnt", int'(frame_cnt), 3);
      check_output("t2_busy", int'(busy), 0);

      // Stream with a 10-cycle source stall after word 15.
      for (int j = 0; j < 74; j++) begin
         apply_stimulus(!(j >= 16 && j < 26), 1'b0);
         if (j >= 16 && j < 26) begin
            check_output("t3_stall_pe", int'(pipe_en), 0);
            check_output("t3_stall_ov", int'(out_valid), 0);
         end
         if (j == 26) check_output("t3_idx_resume", int'(in_idx), 16);
         if (j == 49) check_output("t3_ov49", int'(out_valid), 0);
         if (j == 50) begin
            check_output("t3_ov50", int'(out_valid), 1);
            check_output("t3_sof50", int'(out_sof), 1);
         end
      end

      // Flush pulsed mid-frame at in_idx 10: the frame completes before draining.
      for (int k = 0; k < 32; k++) begin
         apply_stimulus(1'b1, k == 10);
         check_output("t4_in_ready", int'(in_ready), 1);
         if (k == 10) check_output("t4_idx10", int'(in_idx), 10);
      end
      run_drain(-1, 20, pe_cnt, last_eof, done);
      check_output("t4_drain_done", done, 1);
      check_output("t4_drain_pe", pe_cnt, 40);
      check_output("t4_drain_last_eof", last_eof, 1);
      check_output("t4_fcnt", int'(frame_cnt), 6);
      check_output("t4_busy", int'(busy), 0);

      // A flush while idle is ignored.
      apply_stimulus(1'b0, 1'b1);
      check_output("t5_idle_pe", int'(pipe_en), 0);
      check_output("t5_idle_ready", int'(in_ready), 1);
      apply_stimulus(1'b0, 1'b0);
      check_output("t5_idle_pe2", int'(pipe_en), 0);
      check_output("t5_idle_ready2", int'(in_ready), 1);
      check_output("t5_idle_busy", int'(busy), 0);

      // One frame whose last word coincides with a flush; reset mid-drain.
      for (int k = 0; k < 32; k++) begin
         apply_stimulus(1'b1, k == 31);
      end
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b0, 1'b0);
         if (i == 0) check_output("t6_drain_ready", int'(in_ready), 0);
      end
      check_output("t6_busy_pre", int'(busy), 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check_output("t6_rst_in_ready", int'(in_ready), 1);
      check_output("t6_rst_pipe_en", int'(pipe_en), 0);
      check_output("t6_rst_out_valid", int'(out_valid), 0);
      check_output("t6_rst_busy", int'(busy), 0);
      check_output("t6_rst_in_idx", int'(in_idx), 0);
      check_output("t6_rst_fcnt", int'(frame_cnt), 0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 64; k++) begin
         apply_stimulus(1'b1, k == 63);
         if (k == 0) check_output("t6_idx0", int'(in_idx), 0);
         if (k == 40) begin
            check_output("t6_ov40", int'(out_valid), 1);
            check_output("t6_sof40", int'(out_sof), 1);
         end
      end
      run_drain(-1, 0, pe_cnt, last_eof, done);
      check_output("t6_drain_done", done, 1);
      check_output("t6_drain_pe", pe_cnt, 40);
      check_output("t6_fcnt", int'(frame_cnt), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
